// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: streams a sync-framed bitstream into a shadow register
// and commits it atomically. Optional CRC-8 check under `CFG_CRC_EN.
module fpga_cfg_loader #(
   parameter int                CFG_BITS  = 2828,
   parameter int                WORD_W    = 8,
   parameter logic [WORD_W-1:0] SYNC_WORD = 8'hA5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WORD_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                cfg_abort,
   output logic [CFG_BITS-1:0] cfg_bits,
   output logic                cfg_busy,
   output logic                cfg_done,
   output logic                cfg_loaded,
   output logic                cfg_err
);

   localparam int NWORDS = (CFG_BITS + WORD_W - 1) / WORD_W;
   localparam int CNT_W  = $clog2(NWORDS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
`ifdef CFG_CRC_EN
      S_CRC,
      S_ERROR,
`endif
      S_COMMIT
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] cfg_bits_q, cfg_bits_d;
   logic                cfg_loaded_q, cfg_loaded_d;
   logic                cfg_err_q, cfg_err_d;
   logic                accept;

`ifdef CFG_CRC_EN
   logic [7:0]          crc_q, crc_d;

   // CRC-8 (0x07), word shifted in MSB first
   function automatic logic [7:0] crc8_step(
      input logic [7:0]        c,
      input logic [WORD_W-1:0] d
   );
      logic [7:0] r;
      r = c;
      for (int b = WORD_W - 1; b >= 0; b--) begin
         r = {r[6:0], 1'b0} ^ ((r[7] ^ d[b]) ? 8'h07 : 8'h00);
      end
      return r;
   endfunction
`endif

   assign accept     = in_valid && in_ready;
   assign cfg_bits   = cfg_bits_q;
   assign cfg_busy   = (state_q != S_IDLE);
   assign cfg_done   = (state_q == S_COMMIT);
   assign cfg_loaded = cfg_loaded_q;
   assign cfg_err    = cfg_err_q;

   // Words are taken only while idle, loading or awaiting the CRC
   always_comb begin
      in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
`ifdef CFG_CRC_EN
      if (state_q == S_CRC) begin
         in_ready = 1'b1;
      end
`endif
   end

   // Next-state, shadow fill and commit logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      cfg_bits_d   = cfg_bits_q;
      cfg_loaded_d = cfg_loaded_q;
      cfg_err_d    = cfg_err_q;
`ifdef CFG_CRC_EN
      crc_d        = crc_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (accept && (in_data == SYNC_WORD)) begin
               state_d   = S_LOAD;
               cnt_d     = '0;
               cfg_err_d = 1'b0;
`ifdef CFG_CRC_EN
               crc_d     = 8'h00;
`endif
            end
         end
         S_LOAD: begin
            if (cfg_abort) begin
               state_d = S_IDLE;
            end else if (accept) begin
               // Bits past CFG_BITS-1 have no target and fall away
               for (int i = 0; i < CFG_BITS; i++) begin
                  if (CNT_W'(i / WORD_W) == cnt_q) begin
                     shadow_d[i] = in_data[i % WORD_W];
                  end
               end
               cnt_d = cnt_q + 1'b1;
`ifdef CFG_CRC_EN
               crc_d = crc8_step(crc_q, in_data);
`endif
               if (cnt_q == LAST) begin
`ifdef CFG_CRC_EN
                  state_d = S_CRC;
`else
                  state_d = S_COMMIT;
`endif
               end
            end
         end
`ifdef CFG_CRC_EN
         S_CRC: begin
            if (cfg_abort) begin
               state_d = S_IDLE;
            end else if (accept) begin
               state_d = (in_data[7:0] == crc_q) ? S_COMMIT : S_ERROR;
            end
         end
         S_ERROR: begin
            cfg_err_d = 1'b1;
            state_d   = S_IDLE;
         end
`endif
         S_COMMIT: begin
            cfg_bits_d   = shadow_q;
            cfg_loaded_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         shadow_q     <= '0;
         cfg_bits_q   <= '0;
         cfg_loaded_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         cfg_bits_q   <= cfg_bits_d;
         cfg_loaded_q <= cfg_loaded_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

`ifdef CFG_CRC_EN
   // Running CRC over the payload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= 8'h00;
      end else begin
         crc_q <= crc_d;
      end
   end
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader (CFG_BITS=20, WORD_W=8).
// Commits are checked by a monitor against a queue of expected vectors.
module tb_fpga_cfg_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        cfg_abort;
   logic [19:0] cfg_bits;
   logic        cfg_busy;
   logic        cfg_done;
   logic        cfg_loaded;
   logic        cfg_err;

   int          vectors = 0;
   int          miscompares = 0;
   logic [19:0] exp_q[$];

   fpga_cfg_loader #(
      .CFG_BITS (20),
      .WORD_W   (8),
      .SYNC_WORD(8'hA5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cfg_abort (cfg_abort),
      .cfg_bits  (cfg_bits),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .cfg_loaded(cfg_loaded),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference CRC-8 (0x07, init 0, MSB first) for reloads
   function automatic logic [7:0] crc3(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c);
      logic [7:0] r;
      logic [7:0] w[3];
      w[0] = a; w[1] = b; w[2] = c;
      r = 8'h00;
      for (int k = 0; k < 3; k++) begin
         for (int j = 7; j >= 0; j--) begin
            r = {r[6:0], 1'b0} ^ ((r[7] ^ w[k][j]) ? 8'h07 : 8'h00);
         end
      end
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one word and hold it until it is accepted
   task automatic send(input logic [7:0] w);
      int n;
      n = 0;
      in_data  = w;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 20) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: word %h never accepted", w);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic load3(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int gap);
      send(8'hA5);
      idle(gap);
      send(b0);
      idle(gap);
      send(b1);
      idle(gap);
      send(b2);
`ifdef CFG_CRC_EN
      idle(gap);
      send(crc3(b0, b1, b2));
`endif
   endtask

   // Monitor: each cfg_done must match a queued commit
   always begin
      logic [19:0] e;
      @(negedge clk);
      if (rst_n && cfg_done) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_commit: cfg_done with empty queue");
         end else begin
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            chk("commit_bits", 32'(cfg_bits), 32'(e));
            chk("commit_loaded", 32'(cfg_loaded), 32'd1);
            chk("done_one_cycle", 32'(cfg_done), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      cfg_abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_bits", 32'(cfg_bits), 32'h0);
      chk("rst_loaded", 32'(cfg_loaded), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_busy", 32'(cfg_busy), 32'd0);
      chk("rst_done", 32'(cfg_done), 32'd0);
      rst_n = 1'b1;
      idle(1);
      chk("rst_ready", 32'(in_ready), 32'd1);

      // Basic load; top nibble of F5 is padding
      exp_q.push_back(20'h53412);
      load3(8'h12, 8'h34, 8'hF5, 0);
      idle(3);
      chk("t1_loaded", 32'(cfg_loaded), 32'd1);

      // Junk before sync is ignored
      send(8'h00);
      chk("junk0_busy", 32'(cfg_busy), 32'd0);
      send(8'hFF);
      chk("junk1_busy", 32'(cfg_busy), 32'd0);
      send(8'h5A);
      chk("junk2_busy", 32'(cfg_busy), 32'd0);
      send(8'hA5);
      chk("sync_busy", 32'(cfg_busy), 32'd1);
      exp_q.push_back(20'h53412);
      send(8'h12);
      send(8'h34);
      send(8'hF5);
`ifdef CFG_CRC_EN
      send(crc3(8'h12, 8'h34, 8'hF5));
`endif
      idle(3);

      // in_valid toggled every other cycle; A5 inside payload is data
      exp_q.push_back(20'h6A5A5);
      load3(8'hA5, 8'hA5, 8'h06, 1);
      idle(3);

      // Abort after second payload word; word in abort cycle dropped
      send(8'hA5);
      send(8'hAA);
      send(8'hBB);
      cfg_abort = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h0C;
      idle(1);
      cfg_abort = 1'b0;
      in_valid  = 1'b0;
      chk("abort_busy", 32'(cfg_busy), 32'd0);
      idle(3);
      chk("abort_bits", 32'(cfg_bits), 32'h6A5A5);
      chk("abort_loaded", 32'(cfg_loaded), 32'd1);
      chk("abort_err", 32'(cfg_err), 32'd0);
      exp_q.push_back(20'hCBBAA);
      load3(8'hAA, 8'hBB, 8'h0C, 0);
      idle(3);

`ifdef CFG_CRC_EN
      // Good CRC commits, flipped CRC errors out
      exp_q.push_back(20'h53412);
      send(8'hA5);
      send(8'h12);
      send(8'h34);
      send(8'h05);
      send(8'hC2);
      idle(3);
      send(8'hA5);
      send(8'h12);
      send(8'h34);
      send(8'h05);
      send(8'hC3);
      idle(3);
      chk("crc_err_set", 32'(cfg_err), 32'd1);
      chk("crc_err_bits", 32'(cfg_bits), 32'h53412);
      send(8'hA5);
      chk("crc_err_clr", 32'(cfg_err), 32'd0);
      exp_q.push_back(20'h53412);
      send(8'h12);
      send(8'h34);
      send(8'h05);
      send(8'hC2);
      idle(3);
`endif

      // Async reset mid-load
      send(8'hA5);
      send(8'h11);
      send(8'h22);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bits", 32'(cfg_bits), 32'h0);
      chk("mid_rst_loaded", 32'(cfg_loaded), 32'd0);
      chk("mid_rst_busy", 32'(cfg_busy), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(8'h33);
      send(8'h44);
      idle(3);
      chk("post_rst_busy", 32'(cfg_busy), 32'd0);
      chk("post_rst_bits", 32'(cfg_bits), 32'h0);
      chk("post_rst_loaded", 32'(cfg_loaded), 32'd0);
      exp_q.push_back(20'h53412);
      load3(8'h12, 8'h34, 8'hF5, 0);
      idle(4);

      chk("final_err", 32'(cfg_err), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
